// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : MEM-stage load/store unit. Drives a valid/ready data-memory
//             port, aligns and extends load data, and stalls the pipeline.
//  Revision : 1.0
// ============================================================================
module lsu #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid_i,
    input  logic            memread_i,
    input  logic            memwrite_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            done_o,
    output logic            misalign_o,
    output logic            buserr_o,
    output logic            dm_req_o,
    output logic            dm_we_o,
    output logic [XLEN-1:0] dm_addr_o,
    output logic [XLEN-1:0] dm_wdata_o,
    output logic [3:0]      dm_be_o,
    input  logic            dm_ready_i,
    input  logic            dm_rvalid_i,
    input  logic [XLEN-1:0] dm_rdata_i
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_REQ      = 2'd1;
    localparam logic [1:0] c_WAIT     = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;
    localparam logic [7:0] c_CNT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]      r_state, w_next;
    logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
    logic [3:0]      r_be;
    logic            r_we, r_misalign, r_buserr;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [7:0]      r_cnt;

    logic            w_op, w_fault, w_timeout, w_load_done, w_store_done, w_complete;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata, w_load_data;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_op = mem_valid_i & (memread_i | memwrite_i);

    // Unsigned-load encodings are illegal as stores; memread wins when both are set.
    always_comb begin
        w_fault = 1'b0;
        case (funct3_i)
            3'b000:  w_fault = 1'b0;
            3'b001:  w_fault = addr_i[0];
            3'b010:  w_fault = |addr_i[1:0];
            3'b100:  w_fault = ~memread_i;
            3'b101:  w_fault = ~memread_i | addr_i[0];
            default: w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_be    = 4'hF;
        w_wdata = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = dm_rdata_i[{r_lane, 3'b000} +: 8];
    assign w_half = dm_rdata_i[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = dm_rdata_i;
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = dm_rdata_i;
        endcase
    end

    assign w_timeout    = (r_cnt == c_CNT_LAST);
    assign w_store_done = (r_state == c_REQ) & dm_ready_i & r_we;
    assign w_load_done  = ~r_we & (((r_state == c_REQ) & dm_ready_i & dm_rvalid_i) |
                                   ((r_state == c_WAIT) & dm_rvalid_i));
    assign w_complete   = w_store_done | w_load_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (w_op) w_next = w_fault ? c_DONE : c_REQ;
            c_REQ: begin
                if (w_complete)      w_next = c_DONE;
                else if (w_timeout)  w_next = c_DONE;
                else if (dm_ready_i) w_next = c_WAIT;
            end
            c_WAIT:  if (dm_rvalid_i | w_timeout) w_next = c_DONE;
            default: w_next = c_IDLE;
        endcase
    end

    // Reset gates stall so the pipeline is released the instant reset rises.
    always_comb begin
        dm_req_o   = (r_state == c_REQ);
        done_o     = (r_state == c_DONE);
        misalign_o = (r_state == c_DONE) & r_misalign;
        buserr_o   = (r_state == c_DONE) & r_buserr;
        stall_o    = ~reset & (((r_state == c_IDLE) & w_op) |
                               (r_state == c_REQ) | (r_state == c_WAIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_funct3   <= '0;
            r_lane     <= '0;
            r_cnt      <= '0;
            r_misalign <= 1'b0;
            r_buserr   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (w_op) begin
                        r_misalign <= w_fault;
                        r_buserr   <= 1'b0;
                        if (!w_fault) begin
                            r_addr   <= {addr_i[XLEN-1:2], 2'b00};
                            r_lane   <= addr_i[1:0];
                            r_funct3 <= funct3_i;
                            r_we     <= ~memread_i;
                            r_be     <= w_be;
                            r_wdata  <= w_wdata;
                        end
                    end
                end
                c_REQ, c_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_load_done) begin
                        r_rdata <= w_load_data;
                    end else if (w_timeout && !w_complete) begin
                        r_buserr <= 1'b1;
                        r_rdata  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata_o    = r_rdata;
    assign dm_we_o    = r_we;
    assign dm_addr_o  = r_addr;
    assign dm_wdata_o = r_wdata;
    assign dm_be_o    = r_be;

endmodule
`default_nettype wire
